// File: rtl/ecall_ctrl_pkg.sv
// Shared syscall definitions: the four recognised syscall codes (a7 values)
// and the 3-bit controller state encoding, with IDLE at zero.
package syscall_defs;

    localparam int SYS_PRINT_DEC = 1;
    localparam int SYS_HALT      = 10;
    localparam int SYS_PRINT_HEX = 34;
    localparam int SYS_PAUSE     = 50;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_WAIT_GO = 3'd2,
        ST_RESUME  = 3'd3,
        ST_HALTED  = 3'd4
    } ctrlState_t;

endpackage

// File: rtl/ecall_ctrl_hold_timer.sv
// Loadable down-counter that times the display hold of print syscalls.
// isOne flags the last hold cycle so the controller can leave HOLD.
module hold_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         en,
    output logic         isOne
);

    logic [W-1:0] count;

    // Load has priority over counting; the counter parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign isOne = (count == W'(1));

endmodule

// File: rtl/sync_reset_reg.sv
// Generic register cell with synchronous active-high reset to zero and a
// load enable.
module sync_reset_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset wins over enable; otherwise capture d when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ecall_ctrl.sv
// Environment-call sequencer. Watches the ecall in EX/MEM and freezes the
// whole pipeline (pipe_en low) while a print, pause or halt is serviced.
// Handshake: none in the valid/ready sense -- ecall is a level held by the
// frozen pipeline; go is a one-cycle pulse honoured only in WAIT_GO.
// dbg_state exposes the FSM state for checkers.
module ecall_ctrl
    import syscall_defs::*;
#(
    parameter int WIDTH       = 32,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ecall,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a7,
    input  logic             go,
    output logic             pipe_en,
    output logic             halt,
    output logic [WIDTH-1:0] disp_data,
    output logic             disp_hex,
    output logic [WIDTH-1:0] ecall_count,
    output logic [2:0]       dbg_state
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);

    ctrlState_t       state;
    logic             isPrintDec;
    logic             isPrintHex;
    logic             isPrint;
    logic             isPause;
    logic             isHalt;
    logic             accept;
    logic             timerOne;
    logic [WIDTH-1:0] dispDataNext;
    logic             dispHexNext;
    logic [WIDTH-1:0] countNext;
    logic             haltNext;

    // Decode the syscall code and whether the ecall is accepted this cycle.
    always_comb begin
        isPrintDec = (a7 == WIDTH'(SYS_PRINT_DEC));
        isPrintHex = (a7 == WIDTH'(SYS_PRINT_HEX));
        isPrint    = isPrintDec || isPrintHex;
        isPause    = (a7 == WIDTH'(SYS_PAUSE));
        isHalt     = (a7 == WIDTH'(SYS_HALT));
        accept     = (state == ST_IDLE) && ecall;
    end

    // Pipeline enable: frozen from the accepting cycle onward, released
    // for the single RESUME cycle so the serviced ecall leaves EX/MEM.
    always_comb begin
        pipe_en = 1'b0;
        case (state)
            ST_IDLE:   pipe_en = !(accept && (isPrint || isPause || isHalt));
            ST_RESUME: pipe_en = 1'b1;
            default:   pipe_en = 1'b0;
        endcase
    end

    // Next values for the output registers; only an accepted call changes them.
    always_comb begin
        dispDataNext = disp_data;
        dispHexNext  = disp_hex;
        countNext    = ecall_count;
        haltNext     = (state == ST_HALTED) || (accept && isHalt);
        if (accept) begin
            countNext = ecall_count + WIDTH'(1);
            if (isPrint || isPause) begin
                dispDataNext = a0;
            end
            if (isPrint) begin
                dispHexNext = isPrintHex;
            end
        end
    end

    sync_reset_reg #(.W(WIDTH)) u_disp_data (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (dispDataNext),
        .q   (disp_data)
    );

    sync_reset_reg #(.W(1)) u_disp_hex (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (dispHexNext),
        .q   (disp_hex)
    );

    sync_reset_reg #(.W(WIDTH)) u_ecall_count (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (countNext),
        .q   (ecall_count)
    );

    sync_reset_reg #(.W(1)) u_halt (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (haltNext),
        .q   (halt)
    );

    hold_timer #(.W(TW)) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (accept && isPrint),
        .loadVal (TW'(HOLD_CYCLES)),
        .en      (state == ST_HOLD),
        .isOne   (timerOne)
    );

    // Controller state machine; RESUME deliberately ignores ecall because
    // the serviced instruction is still in EX/MEM during that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (isPrint) begin
                            state <= ST_HOLD;
                        end else if (isPause) begin
                            state <= ST_WAIT_GO;
                        end else if (isHalt) begin
                            state <= ST_HALTED;
                        end
                    end
                end
                ST_HOLD: begin
                    if (timerOne) begin
                        state <= ST_RESUME;
                    end
                end
                ST_WAIT_GO: begin
                    if (go) begin
                        state <= ST_RESUME;
                    end
                end
                ST_RESUME: state <= ST_IDLE;
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_ecall_ctrl.sv
// Directed bench for ecall_ctrl with a scoreboard queue: expectations are
// pushed as stimulus is driven and popped as DUT outputs are sampled
// (1 ns after the rising edge or after an input change).
module tb_ecall_ctrl;

    localparam int W    = 32;
    localparam int HOLD = 4;

    logic         clk;
    logic         rst;
    logic         ecall;
    logic [W-1:0] a0;
    logic [W-1:0] a7;
    logic         go;
    logic         pipe_en;
    logic         halt;
    logic [W-1:0] disp_data;
    logic         disp_hex;
    logic [W-1:0] ecall_count;
    logic [2:0]   dbg_state;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];

    logic [W-1:0] exp_count;
    logic [W-1:0] exp_disp;
    logic         exp_hex;

    ecall_ctrl #(.WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .ecall       (ecall),
        .a0          (a0),
        .a7          (a7),
        .go          (go),
        .pipe_en     (pipe_en),
        .halt        (halt),
        .disp_data   (disp_data),
        .disp_hex    (disp_hex),
        .ecall_count (ecall_count),
        .dbg_state   (dbg_state)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard
    task automatic sb_push(input string tag, input logic [W-1:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic sb_check(input logic [W-1:0] obs);
        logic [W-1:0] e;
        string        t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: observed=%0h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        exp_count = '0;
        exp_disp  = '0;
        exp_hex   = 1'b0;
        sb_push({tag, "_pe"}, 1);    sb_check(W'(pipe_en));
        sb_push({tag, "_halt"}, 0);  sb_check(W'(halt));
        sb_push({tag, "_disp"}, 0);  sb_check(disp_data);
        sb_push({tag, "_hex"}, 0);   sb_check(W'(disp_hex));
        sb_push({tag, "_cnt"}, 0);   sb_check(ecall_count);
        sb_push({tag, "_state"}, 0); sb_check(W'(dbg_state));
    endtask

    // Full print sequence from IDLE, ecall held while the pipe is frozen.
    task automatic do_print(input logic [W-1:0] code, input logic [W-1:0] val);
        ecall = 1'b1;
        a7    = code;
        a0    = val;
        exp_count = exp_count + 1;
        exp_disp  = val;
        exp_hex   = (code == 34);
        #1;
        sb_push("print_acc_pe", 0); sb_check(W'(pipe_en));
        sb_push("print_disp", exp_disp);
        sb_push("print_hex", W'(exp_hex));
        sb_push("print_cnt", exp_count);
        tick();
        sb_check(disp_data);
        sb_check(W'(disp_hex));
        sb_check(ecall_count);
        for (int i = 0; i < HOLD; i++) begin
            if (i > 0) tick();
            sb_push("print_hold_pe", 0); sb_check(W'(pipe_en));
        end
        tick();
        sb_push("print_resume_pe", 1);    sb_check(W'(pipe_en));
        sb_push("print_resume_state", 3); sb_check(W'(dbg_state));
        tick();
        ecall = 1'b0;
        #1;
        sb_push("print_idle_pe", 1);    sb_check(W'(pipe_en));
        sb_push("print_idle_state", 0); sb_check(W'(dbg_state));
        sb_push("print_no_dbl_cnt", exp_count); sb_check(ecall_count);
    endtask

    // Directed stimulus
    initial begin
        rst   = 1'b1;
        ecall = 1'b0;
        go    = 1'b0;
        a0    = '0;
        a7    = '0;
        exp_count = '0;
        exp_disp  = '0;
        exp_hex   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_reset_values("reset");

        // Print decimal 0x7B
        do_print(1, 32'h0000_007B);

        // Print hex followed immediately by print decimal
        ecall = 1'b1; a7 = 34; a0 = 32'hDEAD_BEEF;
        exp_count = exp_count + 1;
        #1;
        sb_push("b2b_acc1_pe", 0); sb_check(W'(pipe_en));
        sb_push("b2b_disp1", 32'hDEAD_BEEF);
        sb_push("b2b_hex1", 1);
        sb_push("b2b_cnt1", exp_count);
        tick();
        sb_check(disp_data);
        sb_check(W'(disp_hex));
        sb_check(ecall_count);
        for (int i = 0; i < HOLD - 1; i++) begin
            tick();
            sb_push("b2b_hold1_pe", 0); sb_check(W'(pipe_en));
        end
        tick();
        a7 = 1; a0 = 5;
        #1;
        sb_push("b2b_resume1_pe", 1);    sb_check(W'(pipe_en));
        sb_push("b2b_resume1_state", 3); sb_check(W'(dbg_state));
        tick();
        sb_push("b2b_acc2_pe", 0);        sb_check(W'(pipe_en));
        sb_push("b2b_acc2_state", 0);     sb_check(W'(dbg_state));
        sb_push("b2b_acc2_cnt", exp_count); sb_check(ecall_count);
        exp_count = exp_count + 1;
        sb_push("b2b_disp2", 5);
        sb_push("b2b_hex2", 0);
        sb_push("b2b_cnt2", exp_count);
        tick();
        sb_check(disp_data);
        sb_check(W'(disp_hex));
        sb_check(ecall_count);
        for (int i = 0; i < HOLD - 1; i++) begin
            tick();
            sb_push("b2b_hold2_pe", 0); sb_check(W'(pipe_en));
        end
        tick();
        sb_push("b2b_resume2_pe", 1); sb_check(W'(pipe_en));
        tick();
        ecall = 1'b0;
        #1;
        sb_push("b2b_idle_state", 0);      sb_check(W'(dbg_state));
        sb_push("b2b_idle_cnt", exp_count); sb_check(ecall_count);
        exp_disp = 5;
        exp_hex  = 1'b0;

        // go while IDLE has no effect
        go = 1'b1;
        #1;
        sb_push("idle_go_pe", 1); sb_check(W'(pipe_en));
        tick();
        go = 1'b0;
        #1;
        sb_push("idle_go_state", 0); sb_check(W'(dbg_state));
        sb_push("idle_go_pe2", 1);   sb_check(W'(pipe_en));

        // Pause with a7=50, go coinciding with the accepting cycle
        ecall = 1'b1; a7 = 50; a0 = 7; go = 1'b1;
        exp_count = exp_count + 1;
        exp_disp  = 7;
        #1;
        sb_push("pause_acc_pe", 0); sb_check(W'(pipe_en));
        sb_push("pause_disp", exp_disp);
        sb_push("pause_hex", W'(exp_hex));
        sb_push("pause_cnt", exp_count);
        sb_push("pause_state", 2);
        tick();
        go = 1'b0;
        #1;
        sb_check(disp_data);
        sb_check(W'(disp_hex));
        sb_check(ecall_count);
        sb_check(W'(dbg_state));
        for (int i = 0; i < 20; i++) begin
            tick();
            sb_push("pause_wait_pe", 0); sb_check(W'(pipe_en));
        end
        go = 1'b1;
        #1;
        sb_push("pause_go_pe", 0); sb_check(W'(pipe_en));
        tick();
        go = 1'b0;
        #1;
        sb_push("pause_resume_pe", 1);    sb_check(W'(pipe_en));
        sb_push("pause_resume_state", 3); sb_check(W'(dbg_state));
        tick();
        ecall = 1'b0;
        #1;
        sb_push("pause_idle_state", 0);      sb_check(W'(dbg_state));
        sb_push("pause_idle_cnt", exp_count); sb_check(ecall_count);

        // Unknown syscall: counted only
        ecall = 1'b1; a7 = 99; a0 = 32'hFFFF_FFFF;
        exp_count = exp_count + 1;
        #1;
        sb_push("unk_pe", 1); sb_check(W'(pipe_en));
        tick();
        ecall = 1'b0;
        #1;
        sb_push("unk_cnt", exp_count); sb_check(ecall_count);
        sb_push("unk_state", 0);       sb_check(W'(dbg_state));
        sb_push("unk_disp", exp_disp); sb_check(disp_data);
        sb_push("unk_pe2", 1);         sb_check(W'(pipe_en));

        // Halt: frozen forever, go ignored, cleared only by rst
        ecall = 1'b1; a7 = 10; a0 = 32'h1111_2222;
        exp_count = exp_count + 1;
        #1;
        sb_push("halt_acc_pe", 0);   sb_check(W'(pipe_en));
        sb_push("halt_acc_halt", 0); sb_check(W'(halt));
        tick();
        sb_push("halt_halt", 1);      sb_check(W'(halt));
        sb_push("halt_state", 4);     sb_check(W'(dbg_state));
        sb_push("halt_cnt", exp_count); sb_check(ecall_count);
        for (int i = 0; i < 50; i++) begin
            go = 1'($urandom_range(0, 1));
            tick();
            sb_push("halt_hold_halt", 1); sb_check(W'(halt));
            sb_push("halt_hold_pe", 0);   sb_check(W'(pipe_en));
        end
        go = 1'b0;
        sb_push("halt_disp", exp_disp);  sb_check(disp_data);
        sb_push("halt_cnt2", exp_count); sb_check(ecall_count);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ecall = 1'b0;
        #1;
        check_reset_values("halt_rst");

        // Reset in the middle of HOLD
        ecall = 1'b1; a7 = 34; a0 = 32'h0000_1234;
        tick();
        tick();
        sb_push("midhold_state", 1); sb_check(W'(dbg_state));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ecall = 1'b0;
        #1;
        check_reset_values("hold_rst");

        // A fresh print after reset still gets the full hold
        do_print(34, 32'h0000_ABCD);

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL sb_leftover: observed=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ecall_ctrl.md
# ecall_ctrl

- Sequences the pipeline around environment calls.
- Watches the ecall flag and a0/a7 values presented at the EX/MEM stage outputs.
- Freezes the pipeline while a syscall is serviced: print integer, print hex, pause, halt.
- Drives the common enable of all pipeline registers, the halt indicator and the display latch.

## Interface
Parameters:
- WIDTH, 32, datapath width of a0/a7/display/count
- HOLD_CYCLES, 4, HOLD-state length for print syscalls; must be ≥1

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ecall  in  1  EX/MEM-stage ecall flag
- a0  in  WIDTH  EX/MEM-stage a0 value
- a7  in  WIDTH  EX/MEM-stage a7 value (syscall code)
- go  in  1  single-cycle resume pulse from debounced button
- pipe_en  out  1  enable for every pipeline register and the PC
- halt  out  1  program halted
- disp_data  out  WIDTH  last printed/paused value
- disp_hex  out  1  1 = render disp_data as hex, 0 = decimal
- ecall_count  out  WIDTH  number of accepted ecalls

## Operation
- States: IDLE, HOLD, WAIT_GO, RESUME, HALTED. Registered state; pipe_en is combinational from state and inputs.
- Syscall codes: PRINT_DEC=1, HALT=10, PRINT_HEX=34, PAUSE=50.
- IDLE, ecall=0: pipe_en=1, state unchanged.
- IDLE, ecall=1 accepts the call:
  - ecall_count increments, wrapping modulo 2^WIDTH.
  - a7=1 or 34: pipe_en=0 this cycle; disp_data←a0; disp_hex←(a7==34); timer←HOLD_CYCLES; →HOLD.
  - a7=50: pipe_en=0; disp_data←a0; disp_hex unchanged; →WAIT_GO.
  - a7=10: pipe_en=0; →HALTED.
  - Any other a7: counted only; pipe_en=1; stay IDLE.
- HOLD: pipe_en=0; timer decrements each cycle; when timer==1, →RESUME.
- WAIT_GO: pipe_en=0; go=1 →RESUME; otherwise stay.
- RESUME: pipe_en=1; ecall input ignored, because the serviced ecall is still in EX/MEM and leaves at this edge; →IDLE.
- HALTED: pipe_en=0, halt=1; exits only via rst.
- go is ignored in every state except WAIT_GO.

## Timing
- rst has priority over all inputs. At the edge where rst=1: state←IDLE, disp_data←0, disp_hex←0, ecall_count←0, timer←0.
- Output values after reset: pipe_en=1 (EX/MEM also resets, so ecall=0), halt=0, all registered outputs 0.
- Reset mid-HOLD, mid-WAIT_GO or in HALTED behaves identically to reset from IDLE.
- Print, ecall first visible in cycle N:
  - pipe_en=0 for cycles N..N+HOLD_CYCLES (HOLD_CYCLES+1 cycles).
  - RESUME in cycle N+HOLD_CYCLES+1.
  - disp_data and ecall_count updated from cycle N+1.
- Pause: pipe_en=0 from N until the cycle after go is seen; RESUME is one cycle; go during cycle M gives pipe_en=1 in cycle M+1.
- Halt: pipe_en=0 from cycle N permanently; halt=1 from N+1.
- Back-to-back ecalls: a second ecall reaching EX/MEM at the RESUME edge is seen in IDLE the next cycle and accepted normally. No ecall is ever counted twice.
- go coinciding with the accepting cycle (IDLE) is ignored.

## Structure
- Shared package/header syscall_defs holds the four syscall-code constants and the state encoding (3-bit, IDLE=0).
- One natural sub-module, hold_timer: loadable down-counter of width clog2(HOLD_CYCLES+1), with load, enable and a ==1 flag.
- Output registers use the existing sync_reset_reg cell, with enable held at 1.

## Test plan
- Reset then idle: pipe_en=1, halt=0, disp_data=0, disp_hex=0, ecall_count=0.
- ecall with a7=1, a0=0x0000007B, HOLD_CYCLES=4, ecall held while pipe_en=0:
  - pipe_en low exactly 5 cycles, then one RESUME cycle;
  - disp_data=0x7B, disp_hex=0, ecall_count=1, no double count.
- ecall with a7=34, a0=0xDEADBEEF followed immediately by ecall with a7=1, a0=5:
  - disp_data=0xDEADBEEF, disp_hex=1 after the first call;
  - disp_data=5, disp_hex=0 after the second; ecall_count=2.
- ecall with a7=50, a0=7:
  - pipe_en stays 0 for 20 cycles;
  - a go pulse gives pipe_en=1 one cycle later; a go pulse while IDLE has no effect.
- ecall with a7=10: pipe_en=0 immediately, halt=1 next cycle, unchanged for 50 cycles and any go; rst clears everything.
- ecall with a7=99: ecall_count increments, pipe_en never drops. Separately, assert rst during HOLD: next cycle state is IDLE and all outputs are at reset values.
